// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong delay-line sequencer.
// Holds the state encoding, default widths, minimum length and the tick pipeline stage codes.
package ks_pkg;

    localparam int KS_ADDR_W  = 16;
    localparam int KS_DATA_W  = 16;
    localparam int KS_MIN_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_EXCITE = 2'd2,
        ST_RING   = 2'd3
    } ks_state_e;

    // Tick pipeline position: read issue, data capture, write-back.
    typedef logic [1:0] ks_stg_t;
    localparam ks_stg_t STG_NONE = 2'd0;
    localparam ks_stg_t STG_RD   = 2'd1;
    localparam ks_stg_t STG_CAP  = 2'd2;
    localparam ks_stg_t STG_WR   = 2'd3;

endpackage

// File: rtl/ks_delay_ctrl_if.sv
// RAM port bundle between the delay-line sequencer and its block RAM.
// master: drives read/write address, enables and write data; slave: returns rd_data.
interface ks_delay_ctrl_if
    import ks_pkg::*;
#(
    parameter int ADDR_W = KS_ADDR_W,
    parameter int DATA_W = KS_DATA_W
) ();

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );

endinterface

// File: rtl/ks_wrap_ptr.sv
// Modulo counter for the circular-buffer pointer: counts 0..limit-1 then wraps.
// Ports: clk, rst (sync), clr (load 0), adv (step), limit (modulus); ptr, wrap (ptr is limit-1).
module ks_wrap_ptr
    import ks_pkg::*;
#(
    parameter int W = KS_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] limit,
    output logic [W-1:0] ptr,
    output logic         wrap
);

    logic [W-1:0] ptr_q, ptr_d;

    assign wrap = (ptr_q == limit - W'(1));
    assign ptr  = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr)
            ptr_d = '0;
        else if (adv)
            ptr_d = wrap ? '0 : ptr_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ks_delay_ctrl.sv
// Karplus-Strong delay-line sequencer: per sample tick reads the oldest sample, writes back
// noise (excite) or filter output (ring), and advances the ring pointer; also zero-fills the RAM.
// Ports: a_clk, sclr; sample_tick, trigger, clear_req, delay_len, sustain_len, dnoise, dfilter;
// ram (RAM master bundle); q, q_valid, state, busy, overrun.
module ks_delay_ctrl
    import ks_pkg::*;
#(
    parameter int ADDR_W  = KS_ADDR_W,
    parameter int DATA_W  = KS_DATA_W,
    parameter int MIN_LEN = KS_MIN_LEN
) (
    input  logic              a_clk,
    input  logic              sclr,
    input  logic              sample_tick,
    input  logic              trigger,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [15:0]       sustain_len,
    input  logic [DATA_W-1:0] dnoise,
    input  logic [DATA_W-1:0] dfilter,
    ks_delay_ctrl_if.master   ram,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic [1:0]        state,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] MIN_L = ADDR_W'(MIN_LEN);

    ks_state_e         state_q, state_d;
    ks_stg_t           stg_q, stg_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [15:0]       sus_q, sus_d;
    logic [15:0]       scnt_q, scnt_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;

    logic              inflight, active, trig_ok;
    logic              done, restart, accept;
    logic [ADDR_W-1:0] ptr;
    logic              wrap;

    assign inflight = (stg_q != STG_NONE);
    assign done     = (stg_q == STG_WR);
    assign active   = (state_q == ST_EXCITE) || (state_q == ST_RING);
    assign trig_ok  = trigger && (state_q != ST_CLEAR);

    // A trigger seen while a tick is in flight waits for that tick's
    // write-back edge so the old write completes with the old source.
    assign restart = (trig_ok && !inflight)
                   || (done && (pend_q || trig_ok));

    assign accept = sample_tick && !inflight && (active || trig_ok);

    ks_wrap_ptr #(.W(ADDR_W)) u_ptr (
        .clk   (a_clk),
        .rst   (sclr),
        .clr   (restart),
        .adv   (done),
        .limit (len_q),
        .ptr   (ptr),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        len_d   = len_q;
        clr_d   = clr_q;
        sus_d   = sus_q;
        scnt_d  = scnt_q;
        q_d     = q_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;

        unique case (stg_q)
            STG_NONE: if (accept) stg_d = STG_RD;
            STG_RD:   stg_d = STG_CAP;
            STG_CAP: begin
                stg_d = STG_WR;
                q_d   = ram.rd_data;
            end
            STG_WR:   stg_d = STG_NONE;
        endcase

        if (sample_tick && inflight)
            ovr_d = 1'b1;

        if (trig_ok) begin
            len_d = (delay_len < MIN_L) ? MIN_L : delay_len;
            sus_d = sustain_len;
            if (inflight && !done)
                pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!trig_ok && clear_req) begin
                    state_d = ST_CLEAR;
                    clr_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_d = clr_q + ADDR_W'(1);
                if (&clr_q)
                    state_d = ST_IDLE;
            end
            ST_EXCITE: begin
                // Excite starts at ptr 0, so the first wrap means
                // len noise samples are now in the buffer.
                if (done && wrap)
                    state_d = ST_RING;
            end
            ST_RING: begin
                if (done) begin
                    scnt_d = scnt_q + 16'd1;
                    if (sus_q != 16'd0 && scnt_d == sus_q)
                        state_d = ST_IDLE;
                end
            end
        endcase

        if (restart) begin
            state_d = ST_EXCITE;
            scnt_d  = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge a_clk) begin
        if (sclr) begin
            state_q <= ST_IDLE;
            stg_q   <= STG_NONE;
            len_q   <= '0;
            clr_q   <= '0;
            sus_q   <= '0;
            scnt_q  <= '0;
            q_q     <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            len_q   <= len_d;
            clr_q   <= clr_d;
            sus_q   <= sus_d;
            scnt_q  <= scnt_d;
            q_q     <= q_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ram.rd_en   = (stg_q == STG_RD);
    assign ram.rd_addr = ptr;
    assign ram.wr_en   = done || (state_q == ST_CLEAR);
    assign ram.wr_addr = (state_q == ST_CLEAR) ? clr_q : ptr;
    assign ram.wr_data = !done ? '0
                       : (state_q == ST_EXCITE) ? dnoise : dfilter;

    assign q       = q_q;
    assign q_valid = done;
    assign state   = state_q;
    assign busy    = inflight || (state_q == ST_CLEAR);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_ks_delay_ctrl.sv
// Bench for ks_delay_ctrl: vector table, hand corner sequences and a
// randomized run against a per-address string model.
module tb_ks_delay_ctrl;

    logic        a_clk = 1'b0;
    logic        sclr = 1'b1;
    logic        sample_tick = 1'b0;
    logic        trigger = 1'b0;
    logic        clear_req = 1'b0;
    logic [15:0] delay_len = '0;
    logic [15:0] sustain_len = '0;
    logic [15:0] dnoise = '0;
    logic [15:0] dfilter = '0;
    logic [15:0] q;
    logic        q_valid;
    logic [1:0]  state;
    logic        busy;
    logic        overrun;

    always #5 a_clk = ~a_clk;

    ks_delay_ctrl_if #(.ADDR_W(16), .DATA_W(16)) ram ();

    ks_delay_ctrl #(.ADDR_W(16), .DATA_W(16), .MIN_LEN(2)) dut (
        .a_clk       (a_clk),
        .sclr        (sclr),
        .sample_tick (sample_tick),
        .trigger     (trigger),
        .clear_req   (clear_req),
        .delay_len   (delay_len),
        .sustain_len (sustain_len),
        .dnoise      (dnoise),
        .dfilter     (dfilter),
        .ram         (ram),
        .q           (q),
        .q_valid     (q_valid),
        .state       (state),
        .busy        (busy),
        .overrun     (overrun)
    );

    logic [15:0] mem [0:65535];

    always @(posedge a_clk) begin
        if (ram.wr_en) mem[ram.wr_addr] <= ram.wr_data;
        if (ram.rd_en) ram.rd_data <= mem[ram.rd_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // String model: the buffer is addressed by tick index mod len.
    int          m_len, m_sus, m_n;
    bit          m_act = 1'b0;
    logic [15:0] mm [0:63];
    bit          known [0:63];

    function automatic void model_trig(input int dl, input int sl);
        m_len = (dl < 2) ? 2 : dl;
        m_sus = sl;
        m_n   = 0;
        m_act = 1'b1;
    endfunction

    task automatic model_tick(input logic [15:0] nz, input logic [15:0] fl,
                              output bit act, output logic [15:0] eq,
                              output bit cq, output logic [15:0] ea,
                              output logic [15:0] ewd, output logic [1:0] est);
        int a;
        act = 0; eq = 0; cq = 0; ea = 0; ewd = 0; est = 0;
        if (m_act) begin
            a   = m_n % m_len;
            act = 1;
            ea  = 16'(a);
            eq  = mm[a];
            cq  = known[a];
            ewd = (m_n < m_len) ? nz : fl;
            mm[a]    = ewd;
            known[a] = 1'b1;
            m_n++;
            if (m_n < m_len) est = 2'd2;
            else if (m_sus != 0 && m_n - m_len >= m_sus) begin
                est   = 2'd0;
                m_act = 1'b0;
            end else est = 2'd3;
        end
    endtask

    task automatic do_trig(input logic [15:0] dl, input logic [15:0] sl);
        @(posedge a_clk); #1;
        trigger = 1'b1; delay_len = dl; sustain_len = sl;
        @(posedge a_clk); #1;
        trigger = 1'b0;
    endtask

    task automatic do_tick(input bit trig, input logic [15:0] dl,
                           input logic [15:0] sl, input logic [15:0] nz,
                           input logic [15:0] fl, input bit act,
                           input logic [15:0] eq, input bit cq,
                           input logic [15:0] ea, input logic [15:0] ewd,
                           input logic [1:0] est, input string nm);
        @(posedge a_clk); #1;
        sample_tick = 1'b1; trigger = trig;
        delay_len = dl; sustain_len = sl;
        dnoise = nz; dfilter = fl;
        @(posedge a_clk); #1;
        sample_tick = 1'b0; trigger = 1'b0;
        chk({nm, ".rd_en"}, ram.rd_en, act);
        chk({nm, ".busy1"}, busy, act);
        if (act) chk({nm, ".rd_addr"}, ram.rd_addr, ea);
        @(posedge a_clk); #1;
        @(posedge a_clk); #1;
        chk({nm, ".q_valid"}, q_valid, act);
        chk({nm, ".wr_en"}, ram.wr_en, act);
        if (act) begin
            chk({nm, ".wr_addr"}, ram.wr_addr, ea);
            chk({nm, ".wr_data"}, ram.wr_data, ewd);
            if (cq) chk({nm, ".q"}, q, eq);
        end
        @(posedge a_clk); #1;
        chk({nm, ".state"}, state, est);
        chk({nm, ".busy4"}, busy, 0);
    endtask

    task automatic rtick(input bit trig, input int dl, input int sl);
        logic [15:0] nz, fl, eq, ea, ewd;
        logic [1:0]  est;
        bit          act, cq;
        nz = 16'($urandom);
        fl = 16'($urandom);
        if (trig) model_trig(dl, sl);
        model_tick(nz, fl, act, eq, cq, ea, ewd, est);
        do_tick(trig, 16'(dl), 16'(sl), nz, fl, act, eq, cq, ea, ewd, est,
                trig ? "rtrig_tick" : "rtick");
    endtask

    task automatic rtrig(input int dl, input int sl);
        model_trig(dl, sl);
        do_trig(16'(dl), 16'(sl));
    endtask

    typedef struct {
        bit          trig;
        logic [15:0] dl, sl, nz, fl;
        bit          act;
        logic [15:0] eq, ea, ewd;
        logic [1:0]  est;
    } vec_t;

    function automatic vec_t mk(input bit trig, input int dl, input int sl,
                                input int nz, input int fl, input bit act,
                                input int eq, input int ea, input int ewd,
                                input int est);
        vec_t v;
        v.trig = trig; v.dl = 16'(dl); v.sl = 16'(sl);
        v.nz = 16'(nz); v.fl = 16'(fl); v.act = act;
        v.eq = 16'(eq); v.ea = 16'(ea); v.ewd = 16'(ewd);
        v.est = 2'(est);
        return v;
    endfunction

    vec_t tv [13];
    int   bad, wcnt;
    int   r_dl, r_sl, r_nt;
    bit   r_same;

    initial begin
        tv[0]  = mk(1, 5, 0, 'h1000, 'h0bad, 1, 0,      0, 'h1000, 2);
        tv[1]  = mk(0, 5, 0, 'h1001, 'h0bad, 1, 0,      1, 'h1001, 2);
        tv[2]  = mk(0, 5, 0, 'h1002, 'h0bad, 1, 0,      2, 'h1002, 2);
        tv[3]  = mk(0, 5, 0, 'h1003, 'h0bad, 1, 0,      3, 'h1003, 2);
        tv[4]  = mk(0, 5, 0, 'h1004, 'h0bad, 1, 0,      4, 'h1004, 3);
        tv[5]  = mk(0, 5, 0, 'h1005, 'ha000, 1, 'h1000, 0, 'ha000, 3);
        tv[6]  = mk(0, 5, 0, 'h1006, 'ha001, 1, 'h1001, 1, 'ha001, 3);
        tv[7]  = mk(1, 1, 3, 'h2000, 'h0bad, 1, 'ha000, 0, 'h2000, 2);
        tv[8]  = mk(0, 1, 3, 'h2001, 'h0bad, 1, 'ha001, 1, 'h2001, 3);
        tv[9]  = mk(0, 1, 3, 'h2002, 'hb000, 1, 'h2000, 0, 'hb000, 3);
        tv[10] = mk(0, 1, 3, 'h2003, 'hb001, 1, 'h2001, 1, 'hb001, 3);
        tv[11] = mk(0, 1, 3, 'h2004, 'hb002, 1, 'hb000, 0, 'hb002, 0);
        tv[12] = mk(0, 1, 3, 'h2005, 'hb003, 0, 0,      0, 0,      0);

        repeat (3) @(posedge a_clk);
        #1;
        chk("rst.q", q, 0);
        chk("rst.q_valid", q_valid, 0);
        chk("rst.state", state, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.rd_en", ram.rd_en, 0);
        chk("rst.wr_en", ram.wr_en, 0);
        chk("rst.wr_data", ram.wr_data, 0);
        chk("rst.addr", {ram.rd_addr, ram.wr_addr}, 0);
        sclr = 1'b0;

        @(posedge a_clk); #1;
        clear_req = 1'b1;
        @(posedge a_clk); #1;
        clear_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            if (!(busy && ram.wr_en && ram.wr_addr == 16'(i)
                  && ram.wr_data == 16'h0 && !q_valid && !ram.rd_en))
                bad++;
            sample_tick = (i % 4000 == 7);
            @(posedge a_clk); #1;
        end
        sample_tick = 1'b0;
        chk("clr.bad_cycles", bad, 0);
        chk("clr.state", state, 0);
        chk("clr.busy", busy, 0);
        chk("clr.wr_en_end", ram.wr_en, 0);
        chk("clr.overrun", overrun, 0);

        for (int i = 0; i < 13; i++) begin
            if (tv[i].trig) do_trig(tv[i].dl, tv[i].sl);
            do_tick(1'b0, tv[i].dl, tv[i].sl, tv[i].nz, tv[i].fl,
                    tv[i].act, tv[i].eq, 1'b1, tv[i].ea, tv[i].ewd,
                    tv[i].est, $sformatf("vec%0d", i));
        end

        do_trig(16'd4, 16'd0);
        wcnt = 0;
        @(posedge a_clk); #1; sample_tick = 1'b1;
        @(posedge a_clk); #1; sample_tick = 1'b0; wcnt += int'(ram.wr_en);
        @(posedge a_clk); #1; sample_tick = 1'b1; wcnt += int'(ram.wr_en);
        @(posedge a_clk); #1; sample_tick = 1'b0; wcnt += int'(ram.wr_en);
        repeat (6) begin
            @(posedge a_clk); #1;
            wcnt += int'(ram.wr_en);
        end
        chk("ovr.writes", wcnt, 1);
        chk("ovr.flag", overrun, 1);
        @(posedge a_clk); #1; sample_tick = 1'b1;
        @(posedge a_clk); #1; sample_tick = 1'b0;
        repeat (5) @(posedge a_clk);
        #1;
        chk("ovr.sticky", overrun, 1);
        sclr = 1'b1;
        @(posedge a_clk); #1;
        sclr = 1'b0;
        chk("ovr.cleared", overrun, 0);
        chk("ovr.state", state, 0);

        for (int i = 0; i < 64; i++) known[i] = 1'b0;
        rtrig(6, 0);
        repeat (9) rtick(1'b0, 0, 0);
        chk("retrig.pre_state", state, 3);
        rtick(1'b1, 4, 0);
        repeat (4) rtick(1'b0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            r_dl   = $urandom_range(1, 12);
            r_sl   = $urandom_range(0, 5);
            r_nt   = $urandom_range(1, 20);
            r_same = 1'($urandom_range(0, 1));
            if (r_same) rtick(1'b1, r_dl, r_sl);
            else begin
                rtrig(r_dl, r_sl);
                rtick(1'b0, 0, 0);
            end
            for (int k = 1; k < r_nt; k++) begin
                rtick(1'b0, 0, 0);
                repeat ($urandom_range(0, 3)) @(posedge a_clk);
            end
        end

        rtrig(5, 0);
        @(posedge a_clk); #1; sample_tick = 1'b1;
        @(posedge a_clk); #1; sample_tick = 1'b0;
        @(posedge a_clk); #1; sclr = 1'b1;
        @(posedge a_clk); #1; sclr = 1'b0;
        chk("abort.wr_en", ram.wr_en, 0);
        chk("abort.q_valid", q_valid, 0);
        chk("abort.q", q, 0);
        chk("abort.state", state, 0);
        chk("abort.busy", busy, 0);
        chk("abort.rd_en", ram.rd_en, 0);
        chk("abort.wr_data", ram.wr_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ks_delay_ctrl.md
Name: ks_delay_ctrl

Overview:
- Sequencer for the Karplus-Strong string delay line, implemented as a circular buffer in external single-port-read / single-port-write block RAM. It replaces a wide register shift chain.
- On each audio sample tick it performs three steps:
  - reads the oldest sample and presents it as the string output;
  - writes back either excitation noise (pluck phase) or the loop-filter output (ring phase);
  - advances a modulo-length pointer.
- It also sequences RAM clear, pluck length, and sustain timeout.

Parameters:
- ADDR_W, 16, RAM address width; maximum delay length is 2^ADDR_W-1 samples.
- DATA_W, 16, sample width.
- MIN_LEN, 2, lower clamp on delay length.

Ports:
- a_clk  in  1  sole clock.
- sclr  in  1  synchronous active-high reset.
- sample_tick  in  1  one-cycle audio sample strobe.
- trigger  in  1  pluck request, one-cycle pulse.
- clear_req  in  1  request to zero-fill the whole RAM.
- delay_len  in  ADDR_W  string length in samples; latched on trigger.
- sustain_len  in  16  ring duration in ticks; 0 = infinite; latched on trigger.
- dnoise  in  DATA_W  excitation noise sample.
- dfilter  in  DATA_W  loop-filter output; stable from q_valid until the next write.
- rd_addr  out  ADDR_W  RAM read address.
- rd_en  out  1  RAM read enable.
- rd_data  in  DATA_W  RAM read data, valid 1 cycle after rd_en.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- q  out  DATA_W  string output sample.
- q_valid  out  1  one-cycle pulse when q updates.
- state  out  2  current state: 0=IDLE, 1=CLEAR, 2=EXCITE, 3=RING.
- busy  out  1  high while a tick or clear is in progress.
- overrun  out  1  sticky; a tick arrived while a tick was in progress.

Behaviour:
- Reset (sclr, synchronous): every output is 0; state=IDLE; ptr=0; latched length registers=0.
  - sclr asserted mid-tick or mid-clear aborts the operation; no further RAM write is issued.
  - RAM contents are not touched by sclr.
- Tick pipeline, for a tick accepted at cycle T:
  - T+1: rd_en=1, rd_addr=ptr.
  - T+2: q<=rd_data.
  - T+3: q_valid=1; wr_en=1, wr_addr=ptr, wr_data = dnoise in EXCITE or dfilter in RING; ptr advances.
  - busy is high from T+1 to T+3 inclusive.
  - Read-before-write at the same address, so the effective delay is exactly len.
- Pointer: counts 0..len-1, then wraps to 0. The wrap happens when ptr==len-1 at the advance point.
- Length clamp on trigger: len = max(delay_len, MIN_LEN).
- IDLE: ticks are ignored; no RAM access; q holds its last value.
  - trigger -> EXCITE, with ptr=0, exc_cnt=0, sus_cnt=0, and len and sustain latched.
  - clear_req -> CLEAR.
- CLEAR:
  - Writes 0 to addresses 0..2^ADDR_W-1, one per cycle; busy=1 throughout.
  - Ticks are dropped without setting overrun; trigger is ignored.
  - After the last address -> IDLE.
  - clear_req in any other state is honoured only once that state returns to IDLE.
- EXCITE:
  - Each completed tick increments exc_cnt.
  - When exc_cnt reaches len (buffer fully loaded with noise) -> RING at the T+3 edge.
- RING:
  - Each completed tick increments sus_cnt.
  - If sustain != 0 and sus_cnt reaches sustain -> IDLE.
- Retrigger in EXCITE or RING:
  - Restarts EXCITE with fresh latches and ptr=0.
  - If a tick is in flight, its write completes first using the old pointer and source; the restart takes effect at the next edge.
- trigger and sample_tick in the same cycle from IDLE/RING: the trigger is applied first, and that tick is processed as the first EXCITE tick at ptr 0.
- Overrun: a sample_tick while busy (outside CLEAR) is dropped and sets overrun. overrun is cleared only by sclr.
- Ticks must be at least 4 cycles apart for lossless operation.

Decomposition:
- Package ks_pkg:
  - state encoding enum (IDLE, CLEAR, EXCITE, RING);
  - default ADDR_W/DATA_W constants;
  - MIN_LEN;
  - tick pipeline stage constants.
- Sub-module ks_wrap_ptr: loadable modulo counter with inputs clr, adv and limit, and outputs ptr and wrap. It is instantiated once for the ring pointer.
- All other logic lives inline in ks_delay_ctrl.

Test Plan:
- Reset then clear_req -> busy for 65536 cycles; wr_en with wr_data=0 at addresses 0..65535 in order; state returns to 0; ticks during the clear give no q_valid and overrun stays 0.
- trigger with delay_len=5, dnoise=0x1000+n, ticks every 8 cycles:
  - first 5 ticks write 0x1000..0x1004 at addresses 0..4; state=2, then 3 after the 5th tick;
  - 6th tick gives q=0x1000 and writes dfilter at address 0.
- delay_len=1 -> clamped to 2; writes alternate between addresses 0 and 1; the EXCITE phase lasts 2 ticks.
- sustain_len=3 after EXCITE -> exactly 3 RING ticks, then state=0; further ticks produce no rd_en.
- A tick repeated 2 cycles after the previous tick -> overrun=1 and only one write; overrun stays 1 until sclr.
- trigger with sample_tick in the same cycle during RING at ptr=3 -> that tick reads and writes address 0 with dnoise; exc_cnt restarts.
- sclr asserted at T+2 -> no wr_en at T+3; all outputs are 0 on the next cycle.
